inst_fetch: RTL and testbench

//  Program-store and fetch stage that sits directly upstream of cpu and drives its inst input.

---
 rtl/inst_fetch.sv | 63 ++++++
 tb/tb_inst_fetch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: loadable instruction RAM and PC that issues a program to the cpu one word per clock
module inst_fetch #(
  parameter int N  = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          stall,
  output logic [N-1:0]  inst,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  state_t        state;
  logic [AW:0]   len_q;
  logic [N-1:0]  mem [2**AW];
  logic [AW:0]   len_sat;
  assign len_sat = (prog_len > DEPTH) ? DEPTH : prog_len;
  assign busy    = state != IDLE;
  // program load; the RAM is frozen while a run is in flight and is never cleared by rst
  always_ff @(posedge clk)
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
  // issue sequencer: NOP outside RUN, one word per unstalled cycle, done pulse as inst returns to NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      len_q <= '0;
      inst  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          inst <= '0;
          if (start && prog_len != '0) begin
            pc    <= '0;
            len_q <= len_sat;
            state <= RUN;
          end else if (start) done <= 1'b1;
        end
        RUN: if (!stall) begin
          inst <= mem[pc];
          pc   <= pc + 1'b1;
          if ({1'b0, pc} == len_q - 1'b1) state <= DONE;
        end
        DONE: begin
          inst  <= '0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: table-driven cycle vectors plus directed wrap, saturation and reset sequences
module tb_inst_fetch;
  localparam int A  = 'h312A, B  = 'h5100;
  localparam int W0 = 'h3114, W1 = 'h3203, W2 = 'h4123, W3 = 'h5300;
  localparam int S0 = 'h1111, S1 = 'h2222, S2 = 'h3333, S3 = 'h4444;
  typedef struct {
    logic        rst, wr_en, start, stall;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [6:0]  prog_len;
    logic [15:0] e_inst;
    logic [5:0]  e_pc;
    logic        e_busy, e_done;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0, wr_en = 1'b0, start = 1'b0, stall = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [6:0]  prog_len = '0;
  logic [15:0] inst;
  logic [5:0]  pc;
  logic        busy, done;
  logic        s_wr_en = 1'b0, s_start = 1'b0;
  logic [2:0]  s_prog_len = '0;
  logic [15:0] s_inst;
  logic [1:0]  s_pc;
  logic        s_busy, s_done;
  int checks = 0, failures = 0;
  vec_t vq[$];
  always #5 clk = ~clk;
  inst_fetch #(.N(16), .AW(6)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .prog_len(prog_len), .stall(stall),
    .inst(inst), .pc(pc), .busy(busy), .done(done)
  );
  inst_fetch #(.N(16), .AW(2)) u_small (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
    .start(s_start), .prog_len(s_prog_len), .stall(stall),
    .inst(s_inst), .pc(s_pc), .busy(s_busy), .done(s_done)
  );
  function automatic vec_t mk(int r, int w, int a, int d, int s, int l, int st,
                              int ei, int ep, int eb, int ed);
    vec_t v;
    v.rst = r[0]; v.wr_en = w[0]; v.wr_addr = a[5:0]; v.wr_data = d[15:0];
    v.start = s[0]; v.prog_len = l[6:0]; v.stall = st[0];
    v.e_inst = ei[15:0]; v.e_pc = ep[5:0]; v.e_busy = eb[0]; v.e_done = ed[0];
    return v;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int issued, dones;
    logic [15:0] sw [4];
    sw[0] = 16'(S0); sw[1] = 16'(S1); sw[2] = 16'(S2); sw[3] = 16'(S3);
    vq.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0));
    vq.push_back(mk(0,1,0,A, 0,0,0, 0,0,0,0));
    vq.push_back(mk(0,1,1,B, 0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,2,0, 0,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, A,1,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, B,2,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, 0,2,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,0, 0,2,0,0));
    vq.push_back(mk(0,1,0,W0,0,0,0, 0,2,0,0));
    vq.push_back(mk(0,1,1,W1,0,0,0, 0,2,0,0));
    vq.push_back(mk(0,1,2,W2,0,0,0, 0,2,0,0));
    vq.push_back(mk(0,1,3,W3,1,4,0, 0,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, W0,1,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, W1,2,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, W2,3,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, W3,4,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, 0,4,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,0, 0,4,0,0));
    vq.push_back(mk(0,0,0,0, 1,4,0, 0,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, W0,1,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, W1,2,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, W2,3,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,1, W2,3,1,0));
    vq.push_back(mk(0,0,0,0, 1,1,1, W2,3,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,1, W2,3,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0, W3,4,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,1, 0,4,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,0, 0,4,0,0));
    vq.push_back(mk(0,0,0,0, 1,0,0, 0,4,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,0, 0,4,0,0));
    foreach (vq[i]) begin
      rst = vq[i].rst; wr_en = vq[i].wr_en; wr_addr = vq[i].wr_addr; wr_data = vq[i].wr_data;
      start = vq[i].start; prog_len = vq[i].prog_len; stall = vq[i].stall;
      tick();
      chk("inst", i, 32'(inst), 32'(vq[i].e_inst));
      chk("pc",   i, 32'(pc),   32'(vq[i].e_pc));
      chk("busy", i, 32'(busy), 32'(vq[i].e_busy));
      chk("done", i, 32'(done), 32'(vq[i].e_done));
    end
    rst = 0; wr_en = 0; start = 0; stall = 0;
    // rst mid-run, with a write attempted while busy
    start = 1; prog_len = 7'd4; tick();
    start = 0; wr_en = 1; wr_addr = 6'd0; wr_data = 16'hDEAD; tick();
    wr_en = 0;
    chk("rst_pre_w0", 0, 32'(inst), 32'(W0));
    tick();
    chk("rst_pre_w1", 0, 32'(inst), 32'(W1));
    rst = 1; tick(); rst = 0;
    chk("rst_inst", 0, 32'(inst), 0);
    chk("rst_pc",   0, 32'(pc),   0);
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_done", 0, 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_nodone", i, 32'(done), 0);
      chk("rst_idle",   i, 32'(inst), 0);
    end
    start = 1; prog_len = 7'd1; tick(); start = 0;
    tick();
    chk("rerun_word0", 0, 32'(inst), 32'(W0));
    chk("rerun_pc",    0, 32'(pc),   1);
    tick();
    chk("rerun_done",  0, 32'(done), 1);
    chk("rerun_inst0", 0, 32'(inst), 0);
    // AW=2: full-depth run wraps pc, then an oversized length saturates
    s_wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 6'(i); wr_data = sw[i]; tick();
    end
    s_wr_en = 0;
    s_start = 1; s_prog_len = 3'd4; tick(); s_start = 0;
    chk("wrap_busy", 0, 32'(s_busy), 1);
    chk("wrap_pc0",  0, 32'(s_pc),   0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap_inst", i, 32'(s_inst), 32'(sw[i]));
      chk("wrap_pc",   i, 32'(s_pc),   32'((i + 1) % 4));
    end
    tick();
    chk("wrap_done", 0, 32'(s_done), 1);
    chk("wrap_inst0", 0, 32'(s_inst), 0);
    chk("wrap_idle", 0, 32'(s_busy), 0);
    s_start = 1; s_prog_len = 3'd7; tick(); s_start = 0;
    issued = 0; dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_inst != 16'h0) begin
        chk("sat_word", issued, 32'(s_inst), 32'(sw[issued % 4]));
        issued++;
      end
      if (s_done) dones++;
    end
    chk("sat_issues", 0, 32'(issued), 4);
    chk("sat_dones",  0, 32'(dones),  1);
    chk("sat_pc",     0, 32'(s_pc),   0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
